data_merge: RTL and testbench

- Recombines the two ping-pong AXI-Stream branches produced by the packet-group splitter into one ordered output stream.
- Drains whole groups (packet_size × pp_group beats) alternately from input 1 then input 2, so the original beat order is restored.
- Sits downstream of the per-branch processing paths and upstream of the DMA/output sink.
- Has a one-deep registered output stage, full backpressure, and per-input group counters plus a sticky framing-error flag.

---
 rtl/data_merge.sv | 146 ++++++++++++++
 tb/tb_data_merge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_merge.sv
// data_merge: recombines two ping-pong AXI-Stream branches into one ordered
// stream, draining whole groups alternately from input 1 and input 2.
module data_merge #(
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   packet_size,
    input  logic [31:0]   pp_group,
    output logic [15:0]   counter_group1,
    output logic [15:0]   counter_group2,
    output logic          tlast_err,
    input  logic [DW-1:0] axis_in1_tdata,
    input  logic          axis_in1_tvalid,
    input  logic          axis_in1_tlast,
    output logic          axis_in1_tready,
    input  logic [DW-1:0] axis_in2_tdata,
    input  logic          axis_in2_tvalid,
    input  logic          axis_in2_tlast,
    output logic          axis_in2_tready,
    output logic [DW-1:0] axis_out_tdata,
    output logic          axis_out_tvalid,
    output logic          axis_out_tlast,
    input  logic          axis_out_tready
);

    typedef enum logic {SEL1, SEL2} state_t;

    state_t        state_q, state_d;
    logic [31:0]   beat_cnt_q, beat_cnt_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;
    logic [31:0]   glen_q, glen_d;
    logic [15:0]   psize_q, psize_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          out_valid_q, out_valid_d;
    logic [15:0]   cnt1_q, cnt1_d;
    logic [15:0]   cnt2_q, cnt2_d;
    logic          err_q, err_d;

    logic [31:0]   glen_raw, glen_cfg, glen_eff;
    logic [15:0]   ps_cfg, ps_eff;
    logic          grp_start, can_load, accept;
    logic          sel_valid, sel_last, last_beat, pkt_end;
    logic [DW-1:0] sel_data;

    assign glen_raw  = 32'(packet_size[15:0]) * 32'(pp_group[15:0]);
    assign glen_cfg  = (glen_raw == 32'd0) ? 32'd1 : glen_raw;
    assign ps_cfg    = (packet_size[15:0] == 16'd0) ? 16'd1 : packet_size[15:0];

    // Config is sampled live on a group's first beat, then held until it ends.
    assign grp_start = (beat_cnt_q == 32'd0);
    assign glen_eff  = grp_start ? glen_cfg : glen_q;
    assign ps_eff    = grp_start ? ps_cfg : psize_q;

    assign sel_valid = (state_q == SEL1) ? axis_in1_tvalid : axis_in2_tvalid;
    assign sel_data  = (state_q == SEL1) ? axis_in1_tdata : axis_in2_tdata;
    assign sel_last  = (state_q == SEL1) ? axis_in1_tlast : axis_in2_tlast;

    assign can_load  = !reset && (!out_valid_q || axis_out_tready);
    assign accept    = can_load && sel_valid;
    assign last_beat = (beat_cnt_q == glen_eff - 32'd1);
    assign pkt_end   = (pkt_cnt_q == ps_eff - 16'd1);

    assign axis_in1_tready = can_load && (state_q == SEL1);
    assign axis_in2_tready = can_load && (state_q == SEL2);

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        glen_d      = glen_q;
        psize_d     = psize_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;
        err_d       = err_q;

        if (accept) begin
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_valid_d = 1'b1;
            if (grp_start) begin
                glen_d  = glen_cfg;
                psize_d = ps_cfg;
            end
            if (sel_last && !pkt_end) begin
                err_d = 1'b1;
            end
            if (last_beat) begin
                beat_cnt_d = 32'd0;
                pkt_cnt_d  = 16'd0;
                if (state_q == SEL1) begin
                    state_d = SEL2;
                    cnt1_d  = cnt1_q + 16'd1;
                end else begin
                    state_d = SEL1;
                    cnt2_d  = cnt2_q + 16'd1;
                end
            end else begin
                beat_cnt_d = beat_cnt_q + 32'd1;
                pkt_cnt_d  = pkt_end ? 16'd0 : pkt_cnt_q + 16'd1;
            end
        end else if (out_valid_q && axis_out_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEL1;
            beat_cnt_q  <= '0;
            pkt_cnt_q   <= '0;
            glen_q      <= 32'd1;
            psize_q     <= 16'd1;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            glen_q      <= glen_d;
            psize_q     <= psize_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            err_q       <= err_d;
        end
    end

    assign axis_out_tdata  = out_data_q;
    assign axis_out_tlast  = out_last_q;
    assign axis_out_tvalid = out_valid_q;
    assign counter_group1  = cnt1_q;
    assign counter_group2  = cnt2_q;
    assign tlast_err       = err_q;

endmodule

// File: tb/tb_data_merge.sv
// Scoreboard bench for data_merge: directed group traffic on both branches,
// with a decoupled output monitor checking order, stability and gaps.
module tb_data_merge;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   packet_size = 32'd4;
    logic [31:0]   pp_group = 32'd2;
    logic [15:0]   cnt1, cnt2;
    logic          err;
    logic [DW-1:0] in1_d = '0, in2_d = '0, out_d;
    logic          in1_v = 1'b0, in1_l = 1'b0, in1_r;
    logic          in2_v = 1'b0, in2_l = 1'b0, in2_r;
    logic          out_v, out_l;
    logic          out_r = 1'b1;
    logic          rdy_toggle = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int first_hs = -1;
    int last_hs  = -1;

    logic [DW:0]   exp_q[$];
    logic          held_v = 1'b0;
    logic [DW:0]   held;

    data_merge #(.DW(DW)) dut (
        .clk(clk), .reset(reset),
        .packet_size(packet_size), .pp_group(pp_group),
        .counter_group1(cnt1), .counter_group2(cnt2), .tlast_err(err),
        .axis_in1_tdata(in1_d), .axis_in1_tvalid(in1_v),
        .axis_in1_tlast(in1_l), .axis_in1_tready(in1_r),
        .axis_in2_tdata(in2_d), .axis_in2_tvalid(in2_v),
        .axis_in2_tlast(in2_l), .axis_in2_tready(in2_r),
        .axis_out_tdata(out_d), .axis_out_tvalid(out_v),
        .axis_out_tlast(out_l), .axis_out_tready(out_r)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (rdy_toggle) out_r = ~out_r;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected beats on every output handshake.
    always @(negedge clk) begin
        if (!reset && out_v) begin
            if (held_v) begin
                n_tests++;
                if ({out_l, out_d} !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %0h expected %0h",
                             {out_l, out_d}, held);
                end
            end
            if (out_r) begin
                held_v = 1'b0;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none",
                             {out_l, out_d});
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    if ({out_l, out_d} !== e) begin
                        n_fail++;
                        $display("FAIL out_beat: got %0h expected %0h",
                                 {out_l, out_d}, e);
                    end
                end
            end else begin
                held_v = 1'b1;
                held   = {out_l, out_d};
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic push(input int base, input int n, input logic [31:0] lm);
        for (int i = 0; i < n; i++) exp_q.push_back({lm[i], DW'(base + i)});
    endtask

    task automatic send(input int p, input int base, input int n,
                        input logic [31:0] lm);
        for (int i = 0; i < n; i++) begin
            int  w;
            bit  ok;
            if (p == 1) begin
                in1_d = DW'(base + i); in1_l = lm[i]; in1_v = 1'b1;
            end else begin
                in2_d = DW'(base + i); in2_l = lm[i]; in2_v = 1'b1;
            end
            w  = 0;
            ok = 1'b0;
            while (!ok && w < 400) begin
                @(negedge clk);
                ok = (p == 1) ? in1_r : in2_r;
                @(posedge clk);
                w++;
            end
            #1;
            if (!ok) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: port %0d beat %0d not taken", p, i);
                i = n;
            end
        end
        if (p == 1) in1_v = 1'b0;
        else        in2_v = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_v) && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        n_tests++;
        if (exp_q.size() != 0 || out_v) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input logic [31:0] ps, input logic [31:0] pg);
        reset = 1'b1;
        packet_size = ps;
        pp_group = pg;
        @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(out_v), 64'd0);
        chk("rst_tdata", out_d[63:0], 64'd0);
        chk("rst_tlast", 64'(out_l), 64'd0);
        chk("rst_cnt", {32'd0, cnt1, cnt2}, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_treadys", {62'd0, in1_r, in2_r}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        first_hs = -1;
        last_hs  = -1;
    endtask

    initial begin
        // Baseline: two 8-beat groups per branch, no backpressure, no bubbles.
        do_reset(32'd4, 32'd2);
        push(8'h00, 8, 32'h88); push(8'h10, 8, 32'h88);
        push(8'h08, 8, 32'h88); push(8'h18, 8, 32'h88);
        fork
            send(1, 8'h00, 16, 32'h8888);
            send(2, 8'h10, 16, 32'h8888);
        join
        wait_drain();
        chk("t1_cnt1", 64'(cnt1), 64'd2);
        chk("t1_cnt2", 64'(cnt2), 64'd2);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_no_gap", 64'(last_hs - first_hs), 64'd31);

        // Same traffic with output ready toggling every cycle.
        do_reset(32'd4, 32'd2);
        rdy_toggle = 1'b1;
        push(8'h00, 8, 32'h88); push(8'h10, 8, 32'h88);
        push(8'h08, 8, 32'h88); push(8'h18, 8, 32'h88);
        fork
            send(1, 8'h00, 16, 32'h8888);
            send(2, 8'h10, 16, 32'h8888);
        join
        wait_drain();
        rdy_toggle = 1'b0;
        out_r = 1'b1;
        chk("t2_cnt", {32'd0, cnt1, cnt2}, {32'd0, 16'd2, 16'd2});

        // Branch 2 ready early while branch 1 idles: branch 2 must wait.
        do_reset(32'd4, 32'd2);
        push(8'h20, 8, 32'h88); push(8'h30, 8, 32'h88);
        fork
            send(2, 8'h30, 8, 32'h88);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    chk("t3_in2_ready_idle", 64'(in2_r), 64'd0);
                end
                @(posedge clk);
                #1;
                send(1, 8'h20, 8, 32'h88);
            end
        join
        wait_drain();
        chk("t3_cnt", {32'd0, cnt1, cnt2}, {32'd0, 16'd1, 16'd1});

        // Early tlast on beat 2 of a 4-beat packet sets the sticky error.
        do_reset(32'd4, 32'd1);
        push(8'h40, 4, 32'hC);
        send(1, 8'h40, 2, 32'h0);
        chk("t4_err_before", 64'(err), 64'd0);
        send(1, 8'h42, 1, 32'h1);
        chk("t4_err_set", 64'(err), 64'd1);
        send(1, 8'h43, 1, 32'h1);
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        chk("t4_err_sticky", 64'(err), 64'd1);

        // Zero packet size: group length 1, branches alternate per beat.
        do_reset(32'd0, 32'd5);
        exp_q.push_back({1'b0, DW'(8'hA0)});
        exp_q.push_back({1'b0, DW'(8'hB0)});
        exp_q.push_back({1'b1, DW'(8'hA1)});
        exp_q.push_back({1'b0, DW'(8'hB1)});
        fork
            send(1, 8'hA0, 2, 32'h2);
            send(2, 8'hB0, 2, 32'h0);
        join
        wait_drain();
        chk("t5_cnt", {32'd0, cnt1, cnt2}, {32'd0, 16'd2, 16'd2});
        chk("t5_err", 64'(err), 64'd0);

        // Reset three beats into a group restarts cleanly on branch 1.
        do_reset(32'd4, 32'd2);
        push(8'h50, 3, 32'h0);
        send(1, 8'h50, 3, 32'h0);
        wait_drain();
        do_reset(32'd4, 32'd2);
        push(8'h60, 8, 32'h88); push(8'h70, 8, 32'h88);
        fork
            send(1, 8'h60, 8, 32'h88);
            send(2, 8'h70, 8, 32'h88);
        join
        wait_drain();
        chk("t6_cnt", {32'd0, cnt1, cnt2}, {32'd0, 16'd1, 16'd1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
